// File: rtl/gf2m_mul_ctrl.sv
// Command sequencer for one gf2m_mul instance: load x and s, run N multiply steps,
// wait for done and read back the result words. Define GF2M_MUL_CTRL_TIMEOUT_EN for the done timeout.
module gf2m_mul_ctrl #(
    parameter int WORD_WIDTH = 256,
    parameter int MUL_STEP   = 8
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 1023
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WORD_WIDTH-1:0] req_a,
    input  logic [WORD_WIDTH-1:0] req_b,
    input  logic                  req_mod,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_lo,
    output logic [WORD_WIDTH-1:0] rsp_hi,
    output logic                  busy,
    output logic [WORD_WIDTH-1:0] m_sbus,
    output logic                  m_stox,
    output logic                  m_stos,
    output logic                  m_clear,
    output logic                  m_mod_mul,
    output logic                  m_plain_mul,
    output logic                  m_dbus_sel,
    input  logic [WORD_WIDTH-1:0] m_dbus,
    input  logic                  m_done,
    input  logic                  m_run
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
    ,
    output logic                  err
`endif
);

    localparam int N     = WORD_WIDTH / MUL_STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_X, LOAD_S, MUL, WAIT_DONE, READ_LO, READ_HI, RESP
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      step_cnt;
    logic [WORD_WIDTH-1:0] a_q, b_q;
    logic                  mod_q;

    // m_run is status only; the sequence is timed by the step counter and m_done.
    logic unused_run;
    assign unused_run = m_run;

`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;
    logic            timed_out;

    assign timed_out = (state == WAIT_DONE) && !m_done && (wait_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT_DONE) ? wait_cnt + TO_W'(1) : '0;
            if (timed_out)
                err <= 1'b1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (req_valid) state_next = LOAD_X;
            LOAD_X:    state_next = LOAD_S;
            LOAD_S:    state_next = MUL;
            MUL:       if (step_cnt == LAST_STEP) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (m_done)
                    state_next = READ_LO;
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
                else if (timed_out)
                    state_next = RESP;
`endif
            end
            READ_LO:   state_next = mod_q ? RESP : READ_HI;
            READ_HI:   state_next = RESP;
            RESP:      if (rsp_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        m_stox      = 1'b0;
        m_stos      = 1'b0;
        m_clear     = 1'b0;
        m_mod_mul   = 1'b0;
        m_plain_mul = 1'b0;
        m_dbus_sel  = 1'b0;
        m_sbus      = '0;
        rsp_valid   = 1'b0;
        case (state)
            LOAD_X: begin
                m_stox = 1'b1;
                m_sbus = b_q;
            end
            LOAD_S: begin
                m_stos  = 1'b1;
                m_clear = 1'b1;
                m_sbus  = a_q;
            end
            MUL: begin
                m_mod_mul   = mod_q;
                m_plain_mul = ~mod_q;
            end
            READ_HI: m_dbus_sel = 1'b1;
            RESP:    rsp_valid  = 1'b1;
            default: ;
        endcase
    end

    // Ready depends on state alone so the requester never sees a combinational loop.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            mod_q    <= 1'b0;
            step_cnt <= '0;
            rsp_lo   <= '0;
            rsp_hi   <= '0;
        end else begin
            if (req_valid && req_ready) begin
                a_q   <= req_a;
                b_q   <= req_b;
                mod_q <= req_mod;
            end
            if (state == MUL)
                step_cnt <= (step_cnt == LAST_STEP) ? '0 : step_cnt + CNT_W'(1);
            if (state == READ_LO) begin
                rsp_lo <= m_dbus;
                if (mod_q)
                    rsp_hi <= '0;
            end
            if (state == READ_HI)
                rsp_hi <= m_dbus;
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
            if (timed_out) begin
                rsp_lo <= '1;
                rsp_hi <= '1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gf2m_mul_ctrl.sv
// Directed bench for gf2m_mul_ctrl with a behavioural gf2m_mul model (x^233 + x^74 + 1 reduction).
module tb_gf2m_mul_ctrl;

    localparam int W    = 256;
    localparam int STEP = 8;
    localparam int N    = W / STEP;
    localparam int TO   = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, req_mod;
    logic [W-1:0] req_a, req_b;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_lo, rsp_hi;
    logic         busy;
    logic [W-1:0] m_sbus, m_dbus;
    logic         m_stox, m_stos, m_clear, m_mod_mul, m_plain_mul, m_dbus_sel;
    logic         m_done, m_run;
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    gf2m_mul_ctrl #(
        .WORD_WIDTH(W),
        .MUL_STEP  (STEP)
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT   (TO)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_mod    (req_mod),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .busy       (busy),
        .m_sbus     (m_sbus),
        .m_stox     (m_stox),
        .m_stos     (m_stos),
        .m_clear    (m_clear),
        .m_mod_mul  (m_mod_mul),
        .m_plain_mul(m_plain_mul),
        .m_dbus_sel (m_dbus_sel),
        .m_dbus     (m_dbus),
        .m_done     (m_done),
        .m_run      (m_run)
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    // Multiplier model: stox/stos pulse done, N mul steps then done after an optional delay.
    logic [2*W-1:0] mdl_res;
    logic [W-1:0]   mdl_s, mdl_x;
    int             mdl_steps, mdl_dly;
    logic           mdl_done;
    logic           inj_done = 1'b0;
    int             done_delay = 0;
    bit             no_done = 1'b0;

    function automatic logic [2*W-1:0] clmul(input logic [W-1:0] s, input logic [W-1:0] x);
        logic [2*W-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++)
            if (x[i]) p = p ^ ({{W{1'b0}}, s} << i);
        return p;
    endfunction

    function automatic logic [W-1:0] reduce233(input logic [2*W-1:0] p);
        logic [2*W-1:0] poly, r;
        r = p;
        poly = '0;
        poly[233] = 1'b1;
        poly[74]  = 1'b1;
        poly[0]   = 1'b1;
        for (int i = 2*W-1; i >= 233; i--)
            if (r[i]) r = r ^ (poly << (i - 233));
        return r[W-1:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_done  <= 1'b0;
            mdl_steps <= 0;
            mdl_dly   <= 0;
            mdl_s     <= '0;
            mdl_x     <= '0;
            mdl_res   <= '0;
        end else begin
            mdl_done <= 1'b0;
            if (m_stox) begin mdl_x <= m_sbus; mdl_done <= 1'b1; end
            if (m_stos) begin mdl_s <= m_sbus; mdl_done <= 1'b1; end
            if (m_clear) mdl_steps <= 0;
            if (m_mod_mul || m_plain_mul) begin
                mdl_steps <= mdl_steps + 1;
                if (mdl_steps == N - 1) begin
                    // High word is junk in modular mode; the controller must not forward it.
                    mdl_res <= m_mod_mul ? {{W{1'b1}}, reduce233(clmul(mdl_s, mdl_x))}
                                         : clmul(mdl_s, mdl_x);
                    if (!no_done) begin
                        if (done_delay == 0) mdl_done <= 1'b1;
                        else                 mdl_dly  <= done_delay;
                    end
                end
            end
            if (mdl_dly != 0) begin
                mdl_dly <= mdl_dly - 1;
                if (mdl_dly == 1) mdl_done <= 1'b1;
            end
        end
    end

    assign m_dbus = m_dbus_sel ? mdl_res[2*W-1:W] : mdl_res[W-1:0];
    assign m_done = mdl_done | inj_done;
    assign m_run  = (mdl_steps != 0);

    logic [5:0] cmd;
    assign cmd = {m_stox, m_stos, m_clear, m_mod_mul, m_plain_mul, m_dbus_sel};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_req(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic mode, input int done_cyc, input bit spur, input bit tmo,
                           input int hold, input bit chain, input logic [W-1:0] nxt_a,
                           input logic [W-1:0] nxt_b, input logic nxt_mod,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        int           rsp_cyc;
        logic [5:0]   exp_cmd;
        logic [W-1:0] exp_sbus;
        req_a = a; req_b = b; req_mod = mode; req_valid = 1'b1;
        done_delay = done_cyc - (N + 3);
        no_done    = tmo;
        check({name, " req_ready idle"}, req_ready, 1'b1);
        rsp_cyc = tmo ? (N + 3 + TO) : (mode ? done_cyc + 2 : done_cyc + 3);
        for (int k = 1; k <= rsp_cyc; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            inj_done = spur && (k == 2 || k == 10);
            exp_sbus = '0;
            if (k == 1) begin
                exp_cmd = 6'b100000; exp_sbus = b;
            end else if (k == 2) begin
                exp_cmd = 6'b011000; exp_sbus = a;
            end else if (k <= N + 2) begin
                exp_cmd = mode ? 6'b000100 : 6'b000010;
            end else if (!tmo && !mode && k == done_cyc + 2) begin
                exp_cmd = 6'b000001;
            end else begin
                exp_cmd = 6'b000000;
            end
            check($sformatf("%s c%0d cmd", name, k), cmd, exp_cmd);
            check($sformatf("%s c%0d sbus", name, k), m_sbus, exp_sbus);
            check($sformatf("%s c%0d rsp_valid", name, k), rsp_valid, k == rsp_cyc);
            check($sformatf("%s c%0d busy", name, k), busy, 1'b1);
            check($sformatf("%s c%0d req_ready", name, k), req_ready, 1'b0);
        end
        inj_done = 1'b0;
        check({name, " rsp_lo"}, rsp_lo, exp_lo);
        check({name, " rsp_hi"}, rsp_hi, exp_hi);
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
        check({name, " err"}, err, tmo);
`endif
        if (chain) begin
            req_a = nxt_a; req_b = nxt_b; req_mod = nxt_mod; req_valid = 1'b1;
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            check($sformatf("%s hold%0d rsp_valid", name, h), rsp_valid, 1'b1);
            check($sformatf("%s hold%0d rsp_lo", name, h), rsp_lo, exp_lo);
            check($sformatf("%s hold%0d rsp_hi", name, h), rsp_hi, exp_hi);
            check($sformatf("%s hold%0d req_ready", name, h), req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, " post rsp_valid"}, rsp_valid, 1'b0);
        check({name, " post req_ready"}, req_ready, 1'b1);
        check({name, " post busy"}, busy, 1'b0);
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
        check({name, " post err"}, err, tmo);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x232, x255, e_mod1, e_mod2, e_lo3, e_hi4;
        x232 = '0; x232[232] = 1'b1;
        x255 = '0; x255[255] = 1'b1;
        e_mod1 = '0; e_mod1[231] = 1'b1; e_mod1[146] = 1'b1; e_mod1[72] = 1'b1;
        e_mod2 = '0; e_mod2[74] = 1'b1; e_mod2[0] = 1'b1;
        e_lo3 = x255 | 256'h3;
        e_hi4 = '0; e_hi4[254] = 1'b1;

        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_mod = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset cmd", cmd, 6'b000000);
        check("reset sbus", m_sbus, '0);
        check("reset req_ready", req_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset rsp_lo", rsp_lo, '0);
        check("reset rsp_hi", rsp_hi, '0);
`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
        check("reset err", err, 1'b0);
`endif
        reset = 1'b0;

        // 3 * 5 carry-less = 0xF, done in cycle 35, response in 38
        run_req("plain35", 256'h3, 256'h5, 1'b0, N + 3, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0,
                256'hF, '0);
        // x^232 * x^232 = x^464 = x^231 + x^146 + x^72 mod x^233 + x^74 + 1, response in 37
        run_req("mod232", x232, x232, 1'b1, N + 3, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0,
                e_mod1, '0);
        // (x^255 + 1)(x + 1) = x^256 + x^255 + x + 1; consumer stalls 10 cycles, next request queued
        run_req("stall", x255 | 256'h1, 256'h3, 1'b0, N + 3, 1'b0, 1'b0, 10, 1'b1, x255, x255, 1'b0,
                e_lo3, 256'h1);
        // x^255 * x^255 = x^510 -> high word bit 254, accepted the cycle after the response handshake
        run_req("chained", x255, x255, 1'b0, N + 3, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0,
                '0, e_hi4);

        // Abort in MUL cycle 10
        req_a = 256'h7; req_b = 256'h9; req_mod = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("abort pre cmd", cmd, 6'b000010);
        reset = 1'b1;
        #1;
        check("abort cmd", cmd, 6'b000000);
        check("abort sbus", m_sbus, '0);
        check("abort busy", busy, 1'b0);
        check("abort req_ready", req_ready, 1'b1);
        check("abort rsp_valid", rsp_valid, 1'b0);
        check("abort rsp_hi", rsp_hi, '0);
        @(negedge clk);
        reset = 1'b0;
        // x^232 * x = x^233 = x^74 + 1
        run_req("after_abort", x232, 256'h2, 1'b1, N + 3, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0,
                e_mod2, '0);

        // Spurious done in LOAD_S and MUL, real done in cycle 40, response in 43; 0xFF * 0x3 = 0x101
        run_req("late_done", 256'hFF, 256'h3, 1'b0, 40, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0,
                256'h101, '0);

`ifdef GF2M_MUL_CTRL_TIMEOUT_EN
        // No done at all: err and all-ones response in cycle N+3+TO
        run_req("timeout", 256'h3, 256'h5, 1'b0, N + 3, 1'b0, 1'b1, 2, 1'b0, '0, '0, 1'b0,
                '1, '1);
        no_done = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
